renode_ahb_manager_bridge: RTL

Synthesizable AHB-Lite manager that turns a valid/ready request stream from HDL logic into single AHB transfers on the bus served by the Renode AHB subordinate model, and returns read data and error status on a buffered response stream. It pipelines the next address phase over the current data phase and handles two-cycle ERROR responses. Responses return in request order.

---
 rtl/renode_ahb_pkg.sv | 34 +++
 rtl/renode_ahb_rsp_fifo.sv | 53 +++++
 rtl/renode_ahb_manager_bridge.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/renode_ahb_pkg.sv
// Shared AHB-Lite encodings and the data-phase state type for the Renode AHB manager bridge.
package renode_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE   = 3'd0,
        HSIZE_HALF   = 3'd1,
        HSIZE_WORD   = 3'd2,
        HSIZE_DWORD  = 3'd3,
        HSIZE_4WORD  = 3'd4,
        HSIZE_8WORD  = 3'd5,
        HSIZE_16WORD = 3'd6,
        HSIZE_32WORD = 3'd7
    } hsize_e;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    // DP_IDLE means the data-phase slot is empty; DP_ERR1 is the first cycle of a two-cycle ERROR.
    typedef enum logic [1:0] {
        DP_IDLE = 2'd0,
        DP_DATA = 2'd1,
        DP_ERR1 = 2'd2
    } dp_state_e;

endpackage

// File: rtl/renode_ahb_rsp_fifo.sv
// Two-entry response FIFO; a push and pop in the same cycle keep occupancy and order.
module renode_ahb_rsp_fifo #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & !empty;
    // When full, a push is only legal alongside a pop, which frees the slot being overwritten.
    assign do_push = push & (!full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/renode_ahb_manager_bridge.sv
// AHB-Lite manager: turns a request stream into single transfers with address/data pipelining
// and returns in-order responses through a two-entry FIFO.
module renode_ahb_manager_bridge
    import renode_ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    // Both streams: a beat transfers on a rising HCLK edge where valid and ready are both high;
    // valid, once raised, holds its payload stable until that edge.
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_size,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    output logic [1:0]            dbg_state
);

    localparam int RSP_W = DATA_WIDTH + 1;

    dp_state_e             state;
    dp_state_e             state_nxt;

    logic                  a_valid;
    logic                  a_write;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [2:0]            a_size;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  d_write;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_valid;

    logic                  a_fire;
    logic                  req_fire;
    logic                  rsp_push;
    logic                  rsp_pop;
    logic                  fifo_push;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [RSP_W-1:0]      push_data;
    logic [RSP_W-1:0]      head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [1:0]            fifo_count;
    logic [2:0]            outstanding;

    assign d_valid = (state != DP_IDLE);

    // Every accepted request holds one credit until its response leaves the FIFO.
    assign outstanding = {2'b00, a_valid} + {2'b00, d_valid} + {1'b0, fifo_count};
    assign req_ready   = !HRESET && (outstanding < 3'd2) && (state != DP_ERR1)
                         && (!a_valid || HREADY);
    assign req_fire    = req_valid & req_ready;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= DP_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            DP_IDLE: begin
                if (a_fire) state_nxt = DP_DATA;
            end
            DP_DATA: begin
                if (HREADY) begin
                    state_nxt = a_fire ? DP_DATA : DP_IDLE;
                end else if (HRESP == HRESP_ERROR) begin
                    state_nxt = DP_ERR1;
                end
            end
            DP_ERR1: begin
                if (HREADY) state_nxt = DP_IDLE;
            end
            default: state_nxt = DP_IDLE;
        endcase
    end

    always_comb begin
        a_fire    = a_valid && (state != DP_ERR1) && HREADY;
        rd_word   = d_write ? {DATA_WIDTH{1'b0}} : HRDATA;
        rsp_push  = 1'b0;
        push_data = '0;
        unique case (state)
            DP_DATA: begin
                // HRESP with HREADY outside ERR1 skips the first error cycle; still report an error.
                if (HREADY) begin
                    rsp_push  = 1'b1;
                    push_data = (HRESP == HRESP_ERROR) ? {{DATA_WIDTH{1'b0}}, 1'b1}
                                                       : {rd_word, 1'b0};
                end
            end
            DP_ERR1: begin
                if (HREADY) begin
                    rsp_push  = 1'b1;
                    push_data = {{DATA_WIDTH{1'b0}}, 1'b1};
                end
            end
            default: begin
                rsp_push  = 1'b0;
                push_data = '0;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            a_valid <= 1'b0;
            a_write <= 1'b0;
            a_addr  <= '0;
            a_size  <= 3'd0;
            a_wdata <= '0;
            d_write <= 1'b0;
            d_wdata <= '0;
        end else begin
            if (req_fire) begin
                a_valid <= 1'b1;
                a_write <= req_write;
                a_addr  <= req_addr;
                a_size  <= req_size;
                a_wdata <= req_wdata;
            end else if (a_fire) begin
                a_valid <= 1'b0;
            end
            if (a_fire) begin
                d_write <= a_write;
                d_wdata <= a_wdata;
            end
        end
    end

    // During ERR1 the retained address slot is hidden behind IDLE and re-issued afterwards.
    assign HTRANS    = (a_valid && state != DP_ERR1) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = a_addr;
    assign HWRITE    = a_write;
    assign HSIZE     = a_size;
    assign HWDATA    = d_wdata;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DEFAULT;
    assign dbg_state = state;

    assign fifo_push = rsp_push & (!fifo_full | rsp_pop);
    assign rsp_pop   = rsp_valid & rsp_ready;

    renode_ahb_rsp_fifo #(
        .WIDTH(RSP_W)
    ) u_rsp_fifo (
        .clk    (HCLK),
        .rst    (HRESET),
        .push   (fifo_push),
        .wr_data(push_data),
        .pop    (rsp_pop),
        .rd_data(head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_rdata = rsp_valid ? head[RSP_W-1:1] : {DATA_WIDTH{1'b0}};
    assign rsp_error = rsp_valid & head[0];

endmodule
